// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
//
// Purpose: hardwired control unit for a small accumulator machine. A 3-bit
// sequence counter (SC) steps each instruction through timing states T0..T6.
// Register and memory strobes are decoded combinationally from SC, the
// opcode decode, the latched indirect bit and the datapath status flags.
//
// Ports:
//   CLK        in   1  system clock, rising edge
//   RST        in   1  asynchronous active-high reset
//   IR         in   8  instruction: I=IR[7], opcode=IR[6:4], field=IR[3:0]
//   AC_ZERO    in   1  accumulator is zero
//   AC_SIGN    in   1  accumulator sign bit
//   DR_ZERO    in   1  data register is zero
//   START      in   1  restart request, honoured only while halted
//   T          out  8  one-hot timing step T0..T7
//   D          out  8  one-hot opcode decode of IR[6:4]
//   AR_LD .. MEM_WR  out 1 each  register / memory strobes
//   ALU_OP     out  2  00 AND, 01 ADD, 10 pass DR
//   BUS_SEL    out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 memory
//   HALT       out  1  registered halt flag
// ---------------------------------------------------------------------------
module control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IR,
  input  logic       AC_ZERO,
  input  logic       AC_SIGN,
  input  logic       DR_ZERO,
  input  logic       START,
  output logic [7:0] T,
  output logic [7:0] D,
  output logic       AR_LD,
  output logic       PC_LD,
  output logic       PC_INC,
  output logic       IR_LD,
  output logic       DR_LD,
  output logic       DR_INC,
  output logic       AC_LD,
  output logic       AC_CLR,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic [1:0] ALU_OP,
  output logic [2:0] BUS_SEL,
  output logic       HALT
);

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_MEM  = 3'd7
  } bus_src_e;

  typedef enum logic [1:0] {
    ALU_AND  = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_PASS = 2'd2
  } alu_op_e;

  logic [2:0] sc;
  logic [2:0] sc_next;
  logic       i_r;
  logic       i_r_next;
  logic       halt_q;
  logic       halt_next;
  logic       sc_clr;
  logic       set_halt;
  bus_src_e   bus_src;
  alu_op_e    alu_sel;

  // Decodes are pure functions of the current counter and instruction, so
  // they stay valid even while halted or in reset.
  assign T       = 8'd1 << sc;
  assign D       = 8'd1 << IR[6:4];
  assign HALT    = halt_q;
  assign BUS_SEL = bus_src;
  assign ALU_OP  = alu_sel;

  // State register: sequence counter, latched indirect bit and halt flag.
  // Reset aborts any instruction in flight and leaves the unit at T0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc     <= 3'd0;
      i_r    <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      sc     <= sc_next;
      i_r    <= i_r_next;
      halt_q <= halt_next;
    end
  end

  // Next-state logic. While halted the counter is pinned at T0 and only
  // START can release the unit; once running, START has no effect.
  always_comb begin
    sc_next   = sc;
    i_r_next  = i_r;
    halt_next = halt_q;
    if (halt_q) begin
      sc_next = 3'd0;
      if (START) begin
        halt_next = 1'b0;
      end
    end else begin
      sc_next = sc_clr ? 3'd0 : sc + 3'd1;
      if (sc == 3'd2) begin
        i_r_next = IR[7];
      end
      if (set_halt) begin
        halt_next = 1'b1;
      end
    end
  end

  // Output decode. Every timing step drives at most one bus source and at
  // most one memory strobe. Step/opcode combinations that no instruction
  // defines simply end the instruction, so a corrupted IR or counter can
  // never wedge the sequencer.
  always_comb begin
    AR_LD    = 1'b0;
    PC_LD    = 1'b0;
    PC_INC   = 1'b0;
    IR_LD    = 1'b0;
    DR_LD    = 1'b0;
    DR_INC   = 1'b0;
    AC_LD    = 1'b0;
    AC_CLR   = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    alu_sel  = ALU_AND;
    bus_src  = BUS_NONE;
    sc_clr   = 1'b0;
    set_halt = 1'b0;
    if (!halt_q) begin
      case (sc)
        3'd0: begin
          AR_LD   = 1'b1;
          bus_src = BUS_PC;
        end
        3'd1: begin
          MEM_RD  = 1'b1;
          IR_LD   = 1'b1;
          PC_INC  = 1'b1;
          bus_src = BUS_MEM;
        end
        3'd2: begin
          AR_LD   = 1'b1;
          bus_src = BUS_IR;
        end
        3'd3: begin
          if (D[7]) begin
            sc_clr = 1'b1;
            // Register reference: all selected micro-ops fire together and
            // several true skip conditions still collapse to one PC bump.
            if (!i_r) begin
              AC_CLR   = IR[3];
              PC_INC   = (IR[2] & AC_ZERO) | (IR[1] & ~AC_SIGN);
              set_halt = IR[0];
            end
          end else if (i_r) begin
            MEM_RD  = 1'b1;
            AR_LD   = 1'b1;
            bus_src = BUS_MEM;
          end
        end
        3'd4: begin
          if (D[0] | D[1] | D[2] | D[6]) begin
            MEM_RD  = 1'b1;
            DR_LD   = 1'b1;
            bus_src = BUS_MEM;
          end else if (D[3]) begin
            MEM_WR  = 1'b1;
            bus_src = BUS_AC;
            sc_clr  = 1'b1;
          end else if (D[4]) begin
            PC_LD   = 1'b1;
            bus_src = BUS_AR;
            sc_clr  = 1'b1;
          end else begin
            sc_clr  = 1'b1;
          end
        end
        3'd5: begin
          if (D[0] | D[1] | D[2]) begin
            AC_LD  = 1'b1;
            sc_clr = 1'b1;
            if (D[1]) begin
              alu_sel = ALU_ADD;
            end else if (D[2]) begin
              alu_sel = ALU_PASS;
            end else begin
              alu_sel = ALU_AND;
            end
          end else if (D[6]) begin
            DR_INC = 1'b1;
          end else begin
            sc_clr = 1'b1;
          end
        end
        3'd6: begin
          sc_clr = 1'b1;
          if (D[6]) begin
            MEM_WR  = 1'b1;
            PC_INC  = DR_ZERO;
            bus_src = BUS_DR;
          end
        end
        default: begin
          sc_clr = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
//
// Purpose: self-checking bench for control_unit. A reference model expands
// each instruction into the list of per-step outputs it should produce, and
// the bench compares the DUT against that list cycle by cycle. Inputs are
// driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_control_unit;

  logic       CLK;
  logic       RST;
  logic [7:0] IR;
  logic       AC_ZERO;
  logic       AC_SIGN;
  logic       DR_ZERO;
  logic       START;
  logic [7:0] T;
  logic [7:0] D;
  logic       AR_LD;
  logic       PC_LD;
  logic       PC_INC;
  logic       IR_LD;
  logic       DR_LD;
  logic       DR_INC;
  logic       AC_LD;
  logic       AC_CLR;
  logic       MEM_RD;
  logic       MEM_WR;
  logic [1:0] ALU_OP;
  logic [2:0] BUS_SEL;
  logic       HALT;

  control_unit dut (
    .CLK     (CLK),
    .RST     (RST),
    .IR      (IR),
    .AC_ZERO (AC_ZERO),
    .AC_SIGN (AC_SIGN),
    .DR_ZERO (DR_ZERO),
    .START   (START),
    .T       (T),
    .D       (D),
    .AR_LD   (AR_LD),
    .PC_LD   (PC_LD),
    .PC_INC  (PC_INC),
    .IR_LD   (IR_LD),
    .DR_LD   (DR_LD),
    .DR_INC  (DR_INC),
    .AC_LD   (AC_LD),
    .AC_CLR  (AC_CLR),
    .MEM_RD  (MEM_RD),
    .MEM_WR  (MEM_WR),
    .ALU_OP  (ALU_OP),
    .BUS_SEL (BUS_SEL),
    .HALT    (HALT)
  );

  // Strobe bit positions:
  // {AR_LD, PC_LD, PC_INC, IR_LD, DR_LD, DR_INC, AC_LD, AC_CLR, MEM_RD, MEM_WR}
  localparam logic [9:0] M_AR   = 10'b1000000000;
  localparam logic [9:0] M_PCLD = 10'b0100000000;
  localparam logic [9:0] M_PCI  = 10'b0010000000;
  localparam logic [9:0] M_IR   = 10'b0001000000;
  localparam logic [9:0] M_DR   = 10'b0000100000;
  localparam logic [9:0] M_DRI  = 10'b0000010000;
  localparam logic [9:0] M_ACLD = 10'b0000001000;
  localparam logic [9:0] M_ACC  = 10'b0000000100;
  localparam logic [9:0] M_RD   = 10'b0000000010;
  localparam logic [9:0] M_WR   = 10'b0000000001;
  localparam logic [9:0] M_NONE = 10'b0000000000;

  typedef struct packed {
    logic       halt;
    logic [9:0] str;
    logic [1:0] alu;
    logic [2:0] bus;
    logic [7:0] t;
  } step_t;

  step_t exp_q[$];
  logic  expHalt;
  int    checks;
  int    passes;

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Snapshot of the DUT outputs; ALU_OP only matters when AC is loading.
  function automatic step_t observed();
    step_t s;
    s.halt = HALT;
    s.str  = {AR_LD, PC_LD, PC_INC, IR_LD, DR_LD, DR_INC, AC_LD, AC_CLR, MEM_RD, MEM_WR};
    s.alu  = AC_LD ? ALU_OP : 2'b00;
    s.bus  = BUS_SEL;
    s.t    = T;
    return s;
  endfunction

  // Append the next timing step of the expected instruction trace.
  function automatic void pushStep(input logic [9:0] str, input logic [1:0] alu, input logic [2:0] bus);
    step_t s;
    s.halt = 1'b0;
    s.str  = str;
    s.alu  = alu;
    s.bus  = bus;
    s.t    = 8'd1 << exp_q.size();
    exp_q.push_back(s);
  endfunction

  // Reference model: the full step list of one instruction from its
  // encoding and the flags it will see.
  function automatic void buildTrace(input logic [7:0] ir, input logic acz, input logic acs, input logic drz);
    logic [2:0] op;
    logic       ind;
    int         skips;
    op      = ir[6:4];
    ind     = ir[7];
    expHalt = 1'b0;
    exp_q.delete();
    pushStep(M_AR, 2'b00, 3'd2);
    pushStep(M_RD | M_IR | M_PCI, 2'b00, 3'd7);
    pushStep(M_AR, 2'b00, 3'd5);
    if (op == 3'd7) begin
      if (ind) begin
        pushStep(M_NONE, 2'b00, 3'd0);
      end else begin
        skips = 0;
        if (ir[2] && acz) skips++;
        if (ir[1] && !acs) skips++;
        pushStep((ir[3] ? M_ACC : M_NONE) | ((skips > 0) ? M_PCI : M_NONE), 2'b00, 3'd0);
        expHalt = ir[0];
      end
    end else begin
      if (ind) pushStep(M_RD | M_AR, 2'b00, 3'd7);
      else     pushStep(M_NONE, 2'b00, 3'd0);
      case (op)
        3'd0, 3'd1, 3'd2: begin
          pushStep(M_RD | M_DR, 2'b00, 3'd7);
          pushStep(M_ACLD, op[1:0], 3'd0);
        end
        3'd3: pushStep(M_WR, 2'b00, 3'd4);
        3'd4: pushStep(M_PCLD, 2'b00, 3'd1);
        3'd5: pushStep(M_NONE, 2'b00, 3'd0);
        default: begin
          pushStep(M_RD | M_DR, 2'b00, 3'd7);
          pushStep(M_DRI, 2'b00, 3'd0);
          pushStep(M_WR | (drz ? M_PCI : M_NONE), 2'b00, 3'd3);
        end
      endcase
    end
  endfunction

  // Drive one instruction from T0 and compare every step, stopping early
  // after maxSteps steps when a test wants to interrupt it.
  task automatic runInstr(input string name, input logic [7:0] ir, input logic acz, input logic acs,
                          input logic drz, input logic st, input int maxSteps);
    step_t got;
    IR      = ir;
    AC_ZERO = acz;
    AC_SIGN = acs;
    DR_ZERO = drz;
    START   = st;
    buildTrace(ir, acz, acs, drz);
    #1;
    checks++;
    if (D !== (8'd1 << ir[6:4]))
      $display("[TB] FAIL %s decode D: got %h expected %h", name, D, 8'd1 << ir[6:4]);
    else
      passes++;
    for (int k = 0; k < exp_q.size() && k < maxSteps; k++) begin
      got = observed();
      checks++;
      if (got !== exp_q[k])
        $display("[TB] FAIL %s step T%0d: got %h expected %h", name, k, got, exp_q[k]);
      else
        passes++;
      @(posedge CLK);
      @(negedge CLK);
    end
    START = 1'b0;
  endtask

  task automatic test_reset();
    step_t t0;
    t0 = '{halt: 1'b0, str: M_AR, alu: 2'b00, bus: 3'd2, t: 8'h01};
    RST = 1'b1;
    IR = 8'h00; AC_ZERO = 1'b0; AC_SIGN = 1'b0; DR_ZERO = 1'b0; START = 1'b0;
    #3;
    checks++;
    if (observed() !== t0) $display("[TB] FAIL reset_state: got %h expected %h", observed(), t0);
    else passes++;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if (observed() !== t0) $display("[TB] FAIL async_reset: got %h expected %h", observed(), t0);
    else passes++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_directed();
    runInstr("lda_direct",   8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    runInstr("add_indirect", 8'h95, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    runInstr("and_direct",   8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    runInstr("isz_zero",     8'h60, 1'b0, 1'b0, 1'b1, 1'b0, 99);
    runInstr("isz_nonzero",  8'h60, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    runInstr("cla_sza",      8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 99);
    runInstr("two_skips",    8'h76, 1'b1, 1'b0, 1'b0, 1'b0, 99);
    runInstr("sta",          8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    runInstr("bun",          8'h4A, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    runInstr("reserved",     8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    runInstr("d7_nop",       8'hF1, 1'b1, 1'b0, 1'b0, 1'b0, 99);
    runInstr("after_nop",    8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 99);
  endtask

  task automatic test_halt();
    step_t idle;
    step_t t0;
    logic [7:0] r;
    idle = '{halt: 1'b1, str: M_NONE, alu: 2'b00, bus: 3'd0, t: 8'h01};
    t0   = '{halt: 1'b0, str: M_AR, alu: 2'b00, bus: 3'd2, t: 8'h01};
    runInstr("hlt", 8'h71, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    for (int k = 0; k < 10; k++) begin
      r  = 8'($urandom);
      IR = r;
      #1;
      checks++;
      if (observed() !== idle) $display("[TB] FAIL halt_idle %0d: got %h expected %h", k, observed(), idle);
      else passes++;
      checks++;
      if (D !== (8'd1 << r[6:4])) $display("[TB] FAIL halt_decode %0d: got %h expected %h", k, D, 8'd1 << r[6:4]);
      else passes++;
      @(posedge CLK);
      @(negedge CLK);
    end
    START = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b0;
    checks++;
    if (observed() !== t0) $display("[TB] FAIL restart: got %h expected %h", observed(), t0);
    else passes++;
  endtask

  task automatic test_reset_mid_add();
    step_t t0;
    t0 = '{halt: 1'b0, str: M_AR, alu: 2'b00, bus: 3'd2, t: 8'h01};
    runInstr("add_before_rst", 8'h95, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    checks++;
    if (T !== 8'h20) $display("[TB] FAIL at_t5: got %h expected %h", T, 8'h20);
    else passes++;
    RST = 1'b1;
    #1;
    checks++;
    if (observed() !== t0) $display("[TB] FAIL rst_at_t5: got %h expected %h", observed(), t0);
    else passes++;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (observed() !== t0) $display("[TB] FAIL rst_held: got %h expected %h", observed(), t0);
    else passes++;
    RST = 1'b0;
    runInstr("add_after_rst", 8'h95, 1'b0, 1'b0, 1'b0, 1'b0, 99);
  endtask

  task automatic test_random();
    logic [7:0] r;
    for (int n = 0; n < 40; n++) begin
      r = 8'($urandom);
      runInstr("random", r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), 99);
      if (expHalt) begin
        checks++;
        if (HALT !== 1'b1) $display("[TB] FAIL random_halt ir=%h: got %b expected 1", r, HALT);
        else passes++;
        START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        checks++;
        if (HALT !== 1'b0) $display("[TB] FAIL random_restart ir=%h: got %b expected 0", r, HALT);
        else passes++;
      end
    end
    checks++;
    if (T !== 8'h01) $display("[TB] FAIL random_end_t0: got %h expected %h", T, 8'h01);
    else passes++;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_directed();
    test_halt();
    test_reset_mid_add();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL: CLK  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL: RST  in  1  asynchronous, active-high reset.
REQ-003 SHALL: IR  in  8  instruction register contents; I=IR[7], opcode=IR[6:4], address/field=IR[3:0].
REQ-004 SHALL: AC_ZERO, AC_SIGN, DR_ZERO  in  1 each  datapath status flags, sampled combinationally.
REQ-005 SHALL: START  in  1  level; while high and halted, clears halt on next edge.
REQ-006 SHALL: T  out  8  one-hot timing step T0..T7 from internal 3-bit sequence counter SC.
REQ-007 SHALL: D  out  8  one-hot decode of IR[6:4].
REQ-008 SHALL: AR_LD, PC_LD, PC_INC, IR_LD, DR_LD, DR_INC, AC_LD, AC_CLR, MEM_RD, MEM_WR  out  1 each  register/memory strobes, combinational from SC, D, I, flags.
REQ-009 SHALL: ALU_OP  out  2  00 AND, 01 ADD, 10 pass DR.
REQ-010 SHALL: BUS_SEL  out  3  0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 7 memory.
REQ-011 SHALL: HALT  out  1  registered halt flag.

Function
REQ-012 SHALL: SC increments by 1 each edge while not halted; asserting end-of-instruction (SC_CLR, internal) sets SC to 0 on that edge.
REQ-013 SHALL: fetch T0: AR_LD, BUS_SEL=2.
REQ-014 SHALL: fetch T1: MEM_RD, BUS_SEL=7, IR_LD, PC_INC.
REQ-015 SHALL: decode T2: AR_LD, BUS_SEL=5 (AR loads IR[3:0]); latch I into internal register I_R.
REQ-016 SHALL: T3 with D7=0, I_R=1: MEM_RD, BUS_SEL=7, AR_LD (indirect); I_R=0: no strobes.
REQ-017 SHALL: T3 with D7=1, I_R=0 (register-reference), all selected bits act in same cycle, then SC_CLR: IR[3] AC_CLR; IR[2] skip if AC_ZERO; IR[1] skip if AC_SIGN=0; IR[0] set HALT.
REQ-018 SHALL: any number of skip conditions true -> exactly one PC_INC pulse.
REQ-019 SHALL: T3 with D7=1, I_R=1: no strobes, SC_CLR (NOP).
REQ-020 SHALL: D0/D1/D2: T4 MEM_RD, BUS_SEL=7, DR_LD; T5 AC_LD with ALU_OP 00/01/10, SC_CLR.
REQ-021 SHALL: D3 (STA): T4 MEM_WR, BUS_SEL=4, SC_CLR.
REQ-022 SHALL: D4 (BUN): T4 PC_LD, BUS_SEL=1, SC_CLR.
REQ-023 SHALL: D5 reserved: T4 no strobes, SC_CLR.
REQ-024 SHALL: D6 (ISZ): T4 MEM_RD, BUS_SEL=7, DR_LD; T5 DR_INC; T6 MEM_WR, BUS_SEL=3, PC_INC iff DR_ZERO, SC_CLR.
REQ-025 SHALL: SC never exceeds 6; SC=7 (unreachable) forces SC_CLR, no strobes.
REQ-026 SHALL: at most one of MEM_RD/MEM_WR, and exactly one BUS_SEL source, active per cycle.
REQ-027 SHALL: HALT set on edge ending HLT instruction; while HALT=1, SC held at 0, all strobes 0, BUS_SEL=0, T=0x01.
REQ-028 SHALL: START=1 while HALT=1 clears HALT on next edge; fetch begins the cycle after; START ignored when running.
REQ-029 SHALL: D output always reflects current IR regardless of SC or HALT.

Reset
REQ-030 SHALL: RST=1 immediately forces SC=0, I_R=0, HALT=0, T=0x01; strobes follow combinationally (T0 strobes).
REQ-031 SHALL: RST asserted mid-instruction aborts it; first edge after release executes T0.

Verification
REQ-032 SHALL: IR=0x23 (LDA, direct) -> T0..T5 in 6 cycles, T4 DR_LD+MEM_RD, T5 AC_LD ALU_OP=10, next cycle T0.
REQ-033 SHALL: IR=0x95 (ADD indirect) -> T3 MEM_RD+AR_LD, T5 ALU_OP=01, 6-cycle instruction.
REQ-034 SHALL: IR=0x60, DR_ZERO=1 at T6 -> MEM_WR, BUS_SEL=3, single PC_INC; DR_ZERO=0 -> no PC_INC.
REQ-035 SHALL: IR=0x7C, AC_ZERO=1, AC_SIGN=0 -> at T3 AC_CLR and exactly one PC_INC, instruction length 4 cycles.
REQ-036 SHALL: IR=0x71 -> HALT=1 after T3; 10 idle cycles with T=0x01 and zero strobes; START pulse -> HALT=0, T0 strobes next cycle.
REQ-037 SHALL: RST pulse at T5 of ADD -> AC_LD not issued, SC=0 immediately, T0 strobes on release.
